// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch FIFO with an urgency threshold
// competing against host writes, plus a byte serialiser for 8 bpp pixels.
module vram_arbiter #(
  parameter int ADDR_W          = 19,
  parameter int WORDS_PER_FRAME = 327680,
  parameter int FIFO_DEPTH      = 4,
  parameter int URGENT_LVL      = 2
) (
  input  logic              FCLK,
  input  logic              RST_IN,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [7:0]        PIXEL_DATA,
  output logic              underflow,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int FW = ADDR_W + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [FW-1:0] FRAME_END = FW'(WORDS_PER_FRAME);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] URGENT_C  = CW'(URGENT_LVL);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

  logic [FW-1:0] fetch_addr_p0;
  logic          rd_vld_p1;
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] level;
  logic [1:0]    bsel;

  logic [CW-1:0] occ;
  logic          fifo_empty;
  logic          host_in_frame;
  logic          rd_elig;
  logic          rd_urgent;
  logic          rd_gnt;
  logic          host_gnt;
  logic          pix_take;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  always_comb begin
    occ           = level + CW'(rd_vld_p1);
    fifo_empty    = (level == '0);
    host_in_frame = ({1'b0, host_addr} < FRAME_END);
    rd_elig       = !RST_IN && !frame_start && (fetch_addr_p0 < FRAME_END) && (occ < DEPTH_C);
    rd_urgent     = rd_elig && (occ < URGENT_C);
    host_gnt      = !RST_IN && host_valid && !rd_urgent;
    rd_gnt        = rd_elig && !host_gnt;
    pix_take      = pix_req && !frame_start && !RST_IN;
    pop           = pix_take && !fifo_empty && (bsel == 2'd3);
    push          = rd_vld_p1;
  end

  // Stage p0: grant and RAM strobe
  assign host_ready = host_gnt;
  assign mem_en     = rd_gnt || (host_gnt && host_in_frame);
  assign mem_we     = host_gnt && host_in_frame;
  assign mem_addr   = rd_gnt ? fetch_addr_p0[ADDR_W-1:0] : host_addr;
  assign mem_wdata  = host_data;
  assign PIXEL_DATA = (RST_IN || fifo_empty) ? 8'h00 : pick_byte(fifo_q[rd_ptr], bsel);

  always_ff @(posedge FCLK) begin
    if (RST_IN) begin
      fetch_addr_p0 <= '0;
      rd_vld_p1     <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      bsel          <= 2'd0;
      underflow     <= 1'b0;
    end else if (frame_start) begin
      fetch_addr_p0 <= '0;
      rd_vld_p1     <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      bsel          <= 2'd0;
    end else begin
      if (rd_gnt) fetch_addr_p0 <= fetch_addr_p0 + FW'(1);
      rd_vld_p1 <= rd_gnt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: ;
      endcase
      if (pix_take) begin
        if (fifo_empty) underflow <= 1'b1;
        else            bsel <= bsel + 2'd1;
      end
    end
  end

  // Stage p1: read data lands in the FIFO; stale slots are unreachable after a flush
  always_ff @(posedge FCLK) begin
    if (push) fifo_q[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model plus a queue-based reference of the
// arbitration, FIFO and pixel rules, driven by directed and random stimulus.
module tb_vram_arbiter;
  localparam int AW = 6, WPF = 40, DEPTH = 4, URG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fs, pr, hv;
  logic [AW-1:0] ha;
  logic [31:0] hd;
  logic [7:0] pix;
  logic uf, hready, men, mwe;
  logic [AW-1:0] maddr;
  logic [31:0] mwdata, mrdata;

  vram_arbiter #(.ADDR_W(AW), .WORDS_PER_FRAME(WPF), .FIFO_DEPTH(DEPTH), .URGENT_LVL(URG)) dut (
    .FCLK(clk), .RST_IN(rst), .frame_start(fs), .pix_req(pr),
    .PIXEL_DATA(pix), .underflow(uf),
    .host_valid(hv), .host_ready(hready), .host_addr(ha), .host_data(hd),
    .mem_en(men), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(mrdata)
  );

  // RAM model: unwritten words read back a seeded pattern
  logic [31:0] seed;
  logic [31:0] ram [64];
  bit          wr_flag [64];

  function automatic logic [31:0] init_word(input int a);
    return seed ^ (32'(a) * 32'h9E3779B1);
  endfunction

  always @(posedge clk) begin
    if (men) begin
      if (mwe) begin
        ram[maddr] <= mwdata;
        wr_flag[maddr] <= 1'b1;
      end else begin
        mrdata <= wr_flag[maddr] ? ram[maddr] : init_word(int'(maddr));
      end
    end
  end

  // Reference model state
  int          m_fa, m_bsel, m_infl_addr, e_occ;
  logic [31:0] m_q[$];
  bit          m_infl, m_uf;
  logic [31:0] shadow [64];
  bit          e_en, e_we, e_ready, e_rgnt, e_hgnt, pending;
  logic [AW-1:0] e_addr;
  logic [7:0]  e_pix;
  int          checks = 0, errors = 0;

  task automatic model_eval;
    bit elig, urg;
    e_occ  = m_q.size() + int'(m_infl);
    elig   = !rst && !fs && (m_fa < WPF) && (e_occ < DEPTH);
    urg    = elig && (e_occ < URG);
    e_hgnt = !rst && hv && !urg;
    e_rgnt = elig && !e_hgnt;
    e_ready = e_hgnt;
    e_we   = e_hgnt && (int'(ha) < WPF);
    e_en   = e_rgnt || e_we;
    e_addr = e_rgnt ? AW'(m_fa) : ha;
    e_pix  = (rst || m_q.size() == 0) ? 8'h00 : 8'(m_q[0] >> (8 * m_bsel));
  endtask

  task automatic model_commit;
    if (rst) begin
      m_fa = 0; m_q.delete(); m_infl = 0; m_bsel = 0; m_uf = 0;
    end else if (fs) begin
      if (e_we) shadow[ha] = hd;
      m_fa = 0; m_q.delete(); m_infl = 0; m_bsel = 0;
    end else begin
      if (pr) begin
        if (m_q.size() == 0) m_uf = 1;
        else if (m_bsel == 3) begin void'(m_q.pop_front()); m_bsel = 0; end
        else m_bsel++;
      end
      if (m_infl) m_q.push_back(shadow[m_infl_addr]);
      if (e_we) shadow[ha] = hd;
      m_infl = e_rgnt;
      m_infl_addr = m_fa;
      if (e_rgnt) m_fa++;
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit p, input bit v,
                     input logic [AW-1:0] a, input logic [31:0] d);
    if (pending) model_commit();
    @(negedge clk);
    rst = r; fs = f; pr = p; hv = v; ha = a; hd = d;
    #1;
    model_eval();
    pending = 1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1, 6'd5, 32'hDEAD_BEEF);
      checks++; if (men !== 1'b0) begin errors++; $display("FAIL reset_mem_en cyc=%0d got=%b want=0", i, men); end
      checks++; if (hready !== 1'b0) begin errors++; $display("FAIL reset_host_ready cyc=%0d got=%b want=0", i, hready); end
      checks++; if (pix !== 8'h00) begin errors++; $display("FAIL reset_pixel cyc=%0d got=%h want=00", i, pix); end
    end
  endtask

  task automatic test_fill;
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, '0, '0);
      checks++; if (men !== (i < 4)) begin errors++; $display("FAIL fill_mem_en cyc=%0d got=%b want=%b", i, men, (i < 4)); end
      checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL fill_mem_we cyc=%0d got=%b want=0", i, mwe); end
      if (i < 4) begin
        checks++; if (maddr !== AW'(i)) begin errors++; $display("FAIL fill_addr cyc=%0d got=%0d want=%0d", i, maddr, i); end
      end
      if (i == 0) begin
        checks++; if (uf !== 1'b0) begin errors++; $display("FAIL fill_underflow got=%b want=0", uf); end
      end
    end
    w = init_word(0);
    checks++; if (pix !== w[7:0]) begin errors++; $display("FAIL fill_head_pixel got=%h want=%h", pix, w[7:0]); end
  endtask

  task automatic test_pixels;
    logic [7:0] want [8];
    int refills;
    want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    cyc(0, 0, 0, 1, 6'd0, 32'h4433_2211);
    checks++; if (hready !== 1'b1 || mwe !== 1'b1 || maddr !== 6'd0) begin errors++; $display("FAIL pix_host_wr0 got ready=%b we=%b addr=%0d want 1 1 0", hready, mwe, maddr); end
    cyc(0, 0, 0, 1, 6'd1, 32'h8877_6655);
    checks++; if (hready !== 1'b1 || mwe !== 1'b1 || maddr !== 6'd1) begin errors++; $display("FAIL pix_host_wr1 got ready=%b we=%b addr=%0d want 1 1 1", hready, mwe, maddr); end
    cyc(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, '0, '0);
      checks++; if (men !== 1'b1 || maddr !== AW'(i)) begin errors++; $display("FAIL pix_refetch cyc=%0d got en=%b addr=%0d want 1 %0d", i, men, maddr, i); end
    end
    refills = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, '0, '0);
      checks++; if (pix !== want[i]) begin errors++; $display("FAIL pix_byte idx=%0d got=%h want=%h", i, pix, want[i]); end
      checks++; if (men !== e_en) begin errors++; $display("FAIL pix_mem_en idx=%0d got=%b want=%b", i, men, e_en); end
      if (men === 1'b1) refills++;
    end
    checks++; if (refills == 0) begin errors++; $display("FAIL pix_refill got=%0d reads want>0", refills); end
  endtask

  task automatic test_priority;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, 1, AW'($urandom_range(0, WPF - 1)), $urandom);
      checks++; if (hready !== e_ready) begin errors++; $display("FAIL prio_ready cyc=%0d got=%b want=%b", i, hready, e_ready); end
      checks++; if (men !== e_en || mwe !== e_we) begin errors++; $display("FAIL prio_strobe cyc=%0d got en=%b we=%b want %b %b", i, men, mwe, e_en, e_we); end
      if (e_en) begin
        checks++; if (maddr !== e_addr) begin errors++; $display("FAIL prio_addr cyc=%0d got=%0d want=%0d", i, maddr, e_addr); end
      end
      if (e_occ == 3) begin
        checks++; if (hready !== 1'b1 || mwe !== 1'b1) begin errors++; $display("FAIL prio_occ3_host cyc=%0d got ready=%b we=%b want 1 1", i, hready, mwe); end
      end
      if (e_occ < URG && m_fa < WPF) begin
        checks++; if (hready !== 1'b0 || men !== 1'b1 || mwe !== 1'b0) begin errors++; $display("FAIL prio_urgent_read cyc=%0d got ready=%b en=%b we=%b want 0 1 0", i, hready, men, mwe); end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, 1'($urandom), 1'($urandom),
          AW'($urandom_range(0, 63)), $urandom);
      checks++; if (men !== e_en || mwe !== e_we) begin errors++; $display("FAIL rnd_strobe cyc=%0d got en=%b we=%b want %b %b", i, men, mwe, e_en, e_we); end
      checks++; if (hready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, hready, e_ready); end
      checks++; if (pix !== e_pix) begin errors++; $display("FAIL rnd_pixel cyc=%0d got=%h want=%h", i, pix, e_pix); end
      checks++; if (uf !== m_uf) begin errors++; $display("FAIL rnd_underflow cyc=%0d got=%b want=%b", i, uf, m_uf); end
      if (e_en) begin
        checks++; if (maddr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%0d want=%0d", i, maddr, e_addr); end
      end
      if (e_we) begin
        checks++; if (mwdata !== hd) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", i, mwdata, hd); end
      end
    end
  endtask

  task automatic test_underflow;
    cyc(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1, AW'($urandom_range(0, WPF - 1)), $urandom);
      checks++; if (uf !== 1'b0) begin errors++; $display("FAIL uf_saturated cyc=%0d got=%b want=0", i, uf); end
      checks++; if (pix !== e_pix) begin errors++; $display("FAIL uf_sat_pixel cyc=%0d got=%h want=%h", i, pix, e_pix); end
    end
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 1, 0, '0, '0);
      checks++; if (uf !== m_uf || pix !== e_pix) begin errors++; $display("FAIL uf_drain cyc=%0d got uf=%b pix=%h want %b %h", i, uf, pix, m_uf, e_pix); end
    end
    checks++; if (uf !== 1'b1 || pix !== 8'h00 || men !== 1'b0) begin errors++; $display("FAIL uf_end got uf=%b pix=%h en=%b want 1 00 0", uf, pix, men); end
  endtask

  task automatic test_frame_discard;
    cyc(0, 1, 0, 0, '0, '0);
    checks++; if (men !== 1'b0) begin errors++; $display("FAIL fs_no_read got=%b want=0", men); end
    cyc(0, 0, 0, 0, '0, '0);
    checks++; if (men !== 1'b1 || maddr !== 6'd0) begin errors++; $display("FAIL fs_first_read got en=%b addr=%0d want 1 0", men, maddr); end
    cyc(0, 1, 0, 0, '0, '0);
    checks++; if (men !== 1'b0) begin errors++; $display("FAIL fs_return_no_read got=%b want=0", men); end
    cyc(0, 0, 0, 0, '0, '0);
    checks++; if (men !== 1'b1 || maddr !== 6'd0) begin errors++; $display("FAIL fs_restart got en=%b addr=%0d want 1 0", men, maddr); end
    checks++; if (pix !== 8'h00) begin errors++; $display("FAIL fs_discard got=%h want=00", pix); end
    checks++; if (uf !== 1'b1) begin errors++; $display("FAIL fs_underflow_kept got=%b want=1", uf); end
    cyc(0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 0, '0, '0);
    checks++; if (pix !== e_pix) begin errors++; $display("FAIL fs_new_head got=%h want=%h", pix, e_pix); end
  endtask

  task automatic test_oob_write;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0, '0);
    cyc(0, 0, 0, 1, 6'd40, 32'hCAFE_F00D);
    checks++; if (hready !== 1'b1 || men !== 1'b0) begin errors++; $display("FAIL oob_40 got ready=%b en=%b want 1 0", hready, men); end
    cyc(0, 0, 0, 1, 6'd63, 32'h1234_5678);
    checks++; if (hready !== 1'b1 || men !== 1'b0) begin errors++; $display("FAIL oob_63 got ready=%b en=%b want 1 0", hready, men); end
    cyc(0, 0, 0, 0, '0, '0);
    checks++; if (wr_flag[40] !== 1'b0 || wr_flag[63] !== 1'b0) begin errors++; $display("FAIL oob_ram got written40=%b written63=%b want 0 0", wr_flag[40], wr_flag[63]); end
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; pr = 1'b0; hv = 1'b0; ha = '0; hd = '0;
    pending = 0;
    seed = $urandom;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    m_fa = 0; m_bsel = 0; m_infl = 0; m_infl_addr = 0; m_uf = 0;
    test_reset();
    test_fill();
    test_pixels();
    test_priority();
    test_random();
    test_underflow();
    test_frame_discard();
    test_oob_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 19, memory word-address width.
REQ-002 Parameter: WORDS_PER_FRAME, default 327680, words per frame (1280x1024 pixels, 8 bpp, 4 pixels per word).
REQ-003 Parameter: FIFO_DEPTH, default 4, display prefetch FIFO depth in words.
REQ-004 Parameter: URGENT_LVL, default 2, occupancy below which display reads beat host writes.
REQ-005 Port: FCLK  in  1  sole clock (VGACLK domain); one clock; reset is synchronous and active-high.
REQ-006 Port: RST_IN  in  1  synchronous, active-high reset.
REQ-007 Port: frame_start  in  1  one-cycle pulse at the start of each frame (from the vertical timing logic).
REQ-008 Port: pix_req  in  1  pixel consumed this cycle (driven by DISPLAY_EN).
REQ-009 Port: PIXEL_DATA  out  8  current pixel, RGB332, combinational from the FIFO head.
REQ-010 Port: underflow  out  1  sticky flag, set when the display underruns.
REQ-011 Port: host_valid / host_ready  in / out  1 / 1  host write handshake.
REQ-012 Port: host_addr / host_data  in  ADDR_W / 32  host write word address and data.
REQ-013 Port: mem_en / mem_we  out  1 / 1  single-port synchronous RAM strobe and write enable.
REQ-014 Port: mem_addr / mem_wdata  out  ADDR_W / 32  RAM address and write data.
REQ-015 Port: mem_rdata  in  32  RAM read data, valid exactly 1 cycle after a read strobe.

Function
REQ-016 At most one RAM operation per cycle; mem_en is high only in a cycle where a read or a write is granted.
REQ-017 occ = FIFO words + reads in flight (0 or 1); occ never exceeds FIFO_DEPTH.
REQ-018 Read eligibility: fetch address fa < WORDS_PER_FRAME, and occ < FIFO_DEPTH, and frame_start low.
REQ-019 Urgent read: read eligible and occ < URGENT_LVL.
REQ-020 Grant priority, evaluated each cycle: urgent read, then host write (host_valid high), then non-urgent eligible read, then idle.
REQ-021 Read grant: mem_en=1, mem_we=0, mem_addr=fa; fa increments by 1 the next cycle.
REQ-022 When fa reaches WORDS_PER_FRAME, fetching stops until frame_start; there is no wrap.
REQ-023 Host grant: host_ready=1 (combinational, may depend on host_valid), mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_data; the transfer completes in that cycle.
REQ-024 host_addr >= WORDS_PER_FRAME: the write is granted with host_ready=1 and mem_en=0, so it is accepted and dropped.
REQ-025 mem_rdata is pushed into the FIFO the cycle after a read grant, unless frame_start was high in that cycle; in that case it is discarded.
REQ-026 Byte select bsel (2 bits): PIXEL_DATA = head[8*bsel+7 : 8*bsel]; byte 0 ([7:0]) is displayed first.
REQ-027 pix_req with FIFO non-empty: bsel increments; at bsel=3 the head word is popped and bsel returns to 0.
REQ-028 pix_req with FIFO empty: PIXEL_DATA=0, underflow set, bsel unchanged.
REQ-029 FIFO empty without pix_req: PIXEL_DATA=0.
REQ-030 A push and a pop in the same cycle are both performed; the level is unchanged.
REQ-031 frame_start: the FIFO is flushed, bsel=0 and fa=0 on the next cycle; no read is granted in the frame_start cycle; a host grant in that cycle is still allowed; pix_req is ignored in that cycle.
REQ-032 frame_start does not clear underflow; only reset clears it.
REQ-033 A host transfer is never split or aborted by frame_start or pix_req.

Reset
REQ-034 RST_IN sampled high: next cycle fa=0, FIFO empty, bsel=0, in-flight read discarded, underflow=0.
REQ-035 During reset: mem_en=0, host_ready=0, PIXEL_DATA=0.
REQ-036 First read is granted the cycle after RST_IN deasserts, at mem_addr=0.
REQ-037 Reset asserted mid-frame or mid-host-write takes effect identically; no pending state survives.

Verification
REQ-038 Reset release, no host, no pix_req -> reads at addresses 0,1,2,3 on 4 consecutive cycles, then mem_en=0; FIFO holds 4 words.
REQ-039 FIFO full with words 0x44332211 (head) and 0x88776655, pix_req high for 8 cycles -> PIXEL_DATA = 11,22,33,44,55,66,77,88; a refill read is issued as occ drops.
REQ-040 host_valid held high, occ=3 -> host write granted (host_ready=1, mem_we=1). At occ=1 -> read granted, host_ready=0 until occ >= 2.
REQ-041 pix_req for 20 cycles with the RAM model returning data but the host saturating at occ >= URGENT_LVL -> no underflow. With reads blocked (fa preset to WORDS_PER_FRAME) -> underflow=1 on the first empty pix_req and PIXEL_DATA=0.
REQ-042 frame_start coincident with read data return -> returned word discarded, FIFO empty, next read at address 0; underflow unchanged.
REQ-043 host_addr=WORDS_PER_FRAME, host_valid=1 when granted -> host_ready=1, mem_en=0; RAM contents unchanged.
